// File: rtl/uart_tx_slave.sv
// uart_tx_slave: buffers byte-send requests in a FIFO and serialises them onto txd as 8N1 frames, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits, giving 8E1 frames.
module uart_tx_slave #(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic [31:0] content,
    output logic        busy,
    output logic        idle,
    output logic        txd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLK_PER_BIT);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
    logic par_q, par_d;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d, busy_q, busy_d, idle_q, idle_d;
    logic          push, pop, baud_end;
    logic          unused_content;

    assign unused_content = ^content[31:8];
    assign busy = busy_q;
    assign idle = idle_q;
    assign txd  = txd_q;

    always_comb begin
        baud_end = baud_q == BW'(CLK_PER_BIT - 1);
        push     = en && !busy_q;
        // Pop only at a slot boundary so a queued byte follows the stop bit with no gap.
        pop      = count_q != '0 && (state_q == S_IDLE || (state_q == S_STOP && baud_end));
        count_d  = count_q + CW'(push) - CW'(pop);
        wr_d     = push ? wr_q + AW'(1) : wr_q;
        rd_d     = pop ? rd_q + AW'(1) : rd_q;
        state_d  = state_q;
        baud_d   = (state_q == S_IDLE || baud_end) ? '0 : baud_q + BW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d    = pop ? ^mem[rd_q] : par_q;
`endif
        if (pop) begin
            state_d = S_START;
            baud_d  = '0;
            shift_d = mem[rd_q];
        end else if (baud_end) begin
            case (state_q)
                S_START: begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
                S_DATA: begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                    state_d = bit_q == 3'd7 ? S_PARITY : S_DATA;
`else
                    state_d = bit_q == 3'd7 ? S_STOP : S_DATA;
`endif
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: state_d = S_STOP;
`endif
                S_STOP:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
`ifdef UART_TX_PARITY_EN
        txd_d = state_d == S_START ? 1'b0 : state_d == S_DATA ? shift_d[0] : state_d == S_PARITY ? par_d : 1'b1;
`else
        txd_d = state_d == S_START ? 1'b0 : state_d == S_DATA ? shift_d[0] : 1'b1;
`endif
        busy_d = count_d == CW'(FIFO_DEPTH);
        idle_d = count_d == '0 && state_d == S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= content[7:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            idle_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            idle_q  <= idle_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_slave.sv
// tb_uart_tx_slave: checks txd/busy/idle every cycle against a waveform-queue model of the UART sender.
module tb_uart_tx_slave;
    localparam int C = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic [31:0] content = '0;
    logic        busy, idle, txd;
    int          asserts = 0;
    int          fails = 0;
    int          cyc = 0;
    logic        line[$];
    logic [7:0]  fifo[$];

    always #5 clk = ~clk;

    uart_tx_slave #(.CLK_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rstn(rstn), .en(en), .content(content),
        .busy(busy), .idle(idle), .txd(txd)
    );

    // One frame as the per-cycle line levels it must produce.
    function automatic void add_frame(input logic [7:0] b);
        repeat (C) line.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (C) line.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        repeat (C) line.push_back(^b);
`endif
        repeat (C) line.push_back(1'b1);
    endfunction

    task automatic check(input string tag, input logic got, input logic exp);
        asserts++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        check("txd", txd, line.size() != 0 ? line[0] : 1'b1);
        check("busy", busy, fifo.size() == D);
        check("idle", idle, fifo.size() == 0 && line.size() == 0);
    endtask

    task automatic step(input logic e, input logic [31:0] c);
        logic acc;
        en = e;
        content = c;
        @(posedge clk);
        cyc++;
        if (!rstn) begin
            line.delete();
            fifo.delete();
        end else begin
            acc = e && fifo.size() < D;
            if (line.size() != 0) void'(line.pop_front());
            if (line.size() == 0 && fifo.size() != 0) add_frame(fifo.pop_front());
            if (acc) fifo.push_back(c[7:0]);
        end
        #1 check_all();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    initial begin
        // reset state
        idle_steps(3);
        #2 rstn = 1'b1;
        idle_steps(2);
        // single frame, upper bits ignored
        step(1'b1, 32'hFFFF_FFA5);
        idle_steps(45);
        // five back-to-back requests, one more than the FIFO holds
        for (int i = 1; i <= 5; i++) step(1'b1, 32'(i));
        idle_steps(5 * 10 * C + 10);
        // hold en high while full: only accepted bytes are sent
        for (int i = 0; i < 60; i++) step(1'b1, 32'h0000_0077);
        idle_steps(6 * 10 * C);
        // push and pop on the same edge at the last stop cycle
        for (int i = 0; i < 3; i++) step(1'b1, 32'(8'hC0 + i));
        idle_steps(38);
        step(1'b1, 32'h0000_00E7);
        idle_steps(4 * 11 * C);
        // parity-relevant bytes
        step(1'b1, 32'h0000_0007);
        step(1'b1, 32'h0000_0003);
        idle_steps(2 * 11 * C + 5);
        // reset during data bit 3 of 8'h3C with two bytes queued
        step(1'b1, 32'h0000_003C);
        step(1'b1, 32'h0000_00AA);
        step(1'b1, 32'h0000_0055);
        idle_steps(16);
        #2 rstn = 1'b0;
        line.delete();
        fifo.delete();
        #1 check_all();
        idle_steps(2);
        #2 rstn = 1'b1;
        idle_steps(60);
        // random traffic
        for (int i = 0; i < 600; i++) step($urandom_range(0, 3) == 0, $urandom());
        idle_steps(D * 11 * C + 10);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
